// File: rtl/ad9826_pkg.sv
// Shared definitions for the AD9826 RAM packer: FSM states, window defaults,
// and the frame header layout used when AD9826_PACKER_HEADER_EN is defined.
package ad9826_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 10;
    localparam int WORD_BYTES = 4;

    // Header word: {frame_cnt[15:0], 6'b0, length[9:0]}
    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_W   = 10;
    localparam int HDR_CNT_LSB = 16;
    localparam int HDR_CNT_W   = 16;

    function automatic logic [31:0] mk_header(input logic [HDR_CNT_W-1:0] cnt,
                                              input logic [HDR_LEN_W-1:0] len);
        logic [31:0] h;
        h = '0;
        h[HDR_CNT_LSB +: HDR_CNT_W] = cnt;
        h[HDR_LEN_LSB +: HDR_LEN_W] = len;
        return h;
    endfunction

endpackage

// File: rtl/ad9826_ram_packer.sv
// Packs 16-bit AD9826 samples pairwise into 32-bit BRAM words, one frame per
// start pulse, with done pulse, sticky irq and sticky overflow.
// Optional: AD9826_PACKER_HEADER_EN prepends a {frame_cnt, length} header word
// at address 0 of every non-empty frame.
module ad9826_ram_packer
    import ad9826_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_in,
    input  logic [9:0]          length_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid_in,
    input  logic                irq_clr_in,
    output logic                ram_wr_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [31:0]         ram_data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                irq_o,
    output logic                overflow_o,
    output logic [ADDR_W-2:0]   word_count_o
);

    localparam int                CAP_WORDS = (1 << ADDR_W) / WORD_BYTES;
    localparam logic [ADDR_W-2:0] CAP       = (ADDR_W-1)'(CAP_WORDS);

    state_e              state_q, state_d;
    logic [9:0]          len_q, len_d;
    logic [9:0]          cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] low_q, low_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-2:0]   wcnt_q, wcnt_d;
    logic                wr_q, wr_d;
    logic [31:0]         data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                irq_q, irq_d;
    logic                ovf_q, ovf_d;
    logic                req_wr;
    logic [31:0]         req_data;
`ifdef AD9826_PACKER_HEADER_EN
    logic [15:0]         fcnt_q, fcnt_d;
`endif

    // Next-state: FSM, sample pairing, write request arbitration against window capacity
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        low_d    = low_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        wr_d     = 1'b0;
        data_d   = data_q;
        ovf_d    = ovf_q;
        irq_d    = irq_q;
        done_d   = 1'b0;
        req_wr   = 1'b0;
        req_data = '0;
`ifdef AD9826_PACKER_HEADER_EN
        fcnt_d   = fcnt_q;
`endif

        // Address follows the presented write by one cycle; wraps mod 2^ADDR_W.
        if (wr_q) addr_d = addr_q + ADDR_W'(WORD_BYTES);

        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    len_d   = length_in;
                    cnt_d   = '0;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = (length_in == '0) ? S_DONE : S_CAPTURE;
`ifdef AD9826_PACKER_HEADER_EN
                    // Header occupies word 0; the window always has room for it.
                    if (length_in != '0) begin
                        wr_d   = 1'b1;
                        data_d = mk_header(fcnt_q, length_in);
                        wcnt_d = (ADDR_W-1)'(1);
                    end
`endif
                end
            end
            S_CAPTURE: begin
                if (sample_valid_in) begin
                    cnt_d = cnt_q + 10'd1;
                    if (!cnt_q[0]) begin
                        low_d = sample_in;
                    end else begin
                        req_wr   = 1'b1;
                        req_data = {sample_in, low_q};
                    end
                    if (cnt_d == len_q) state_d = len_q[0] ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                req_wr   = 1'b1;
                req_data = {{SAMPLE_W{1'b0}}, low_q};
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef AD9826_PACKER_HEADER_EN
                fcnt_d  = fcnt_q + 16'd1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Full window: drop the write, flag it, keep counting samples.
        if (req_wr) begin
            if (wcnt_q == CAP) begin
                ovf_d = 1'b1;
            end else begin
                wr_d   = 1'b1;
                data_d = req_data;
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        // Set beats clear when both land together.
        if (state_q == S_DONE)  irq_d = 1'b1;
        else if (irq_clr_in)    irq_d = 1'b0;

        busy_d = (state_d == S_CAPTURE) || (state_d == S_FLUSH);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            low_q   <= '0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef AD9826_PACKER_HEADER_EN
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
`ifdef AD9826_PACKER_HEADER_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign ram_wr_o     = wr_q;
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign irq_o        = irq_q;
    assign overflow_o   = ovf_q;
    assign word_count_o = wcnt_q;

endmodule

// File: tb/tb_ad9826_ram_packer.sv
// Directed bench for ad9826_ram_packer: a default-window instance plus a
// 4-word-window instance sharing the same stimulus.
module tb_ad9826_ram_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [9:0]  length_in = '0;
    logic [15:0] sample_in = '0;
    logic        sample_valid_in = 1'b0;
    logic        irq_clr_in = 1'b0;

    logic        ram_wr_o, busy_o, done_o, irq_o, overflow_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic [8:0]  word_count_o;

    logic        wr_s, busy_s, done_s, irq_s, ovf_s;
    logic [3:0]  addr_s;
    logic [31:0] data_s;
    logic [2:0]  wc_s;

    int n_chk = 0;
    int n_fail = 0;

    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wa_s[$];
    logic [31:0] wd_s[$];
    int dn = 0;
    int dn_s = 0;

`ifdef AD9826_PACKER_HEADER_EN
    localparam int HOFF = 4;
`else
    localparam int HOFF = 0;
`endif

    ad9826_ram_packer #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .length_in(length_in),
        .sample_in(sample_in), .sample_valid_in(sample_valid_in), .irq_clr_in(irq_clr_in),
        .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o), .overflow_o(overflow_o),
        .word_count_o(word_count_o)
    );

    ad9826_ram_packer #(.ADDR_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .length_in(length_in),
        .sample_in(sample_in), .sample_valid_in(sample_valid_in), .irq_clr_in(irq_clr_in),
        .ram_wr_o(wr_s), .ram_addr_o(addr_s), .ram_data_o(data_s),
        .busy_o(busy_s), .done_o(done_s), .irq_o(irq_s), .overflow_o(ovf_s),
        .word_count_o(wc_s)
    );

    always #5 clk = ~clk;

    // Log writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (ram_wr_o) begin wa.push_back(ram_addr_o); wd.push_back(ram_data_o); end
        if (done_o) dn++;
        if (wr_s) begin wa_s.push_back(addr_s); wd_s.push_back(data_s); end
        if (done_s) dn_s++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [15:0] s);
        sample_in = s;
        sample_valid_in = 1'b1;
        step();
        sample_valid_in = 1'b0;
    endtask

    // Runs one frame on the shared inputs and checks per-cycle latencies on dut.
    task automatic run_frame(input int len, input logic [15:0] base, input int gap);
        start_in = 1'b1;
        length_in = 10'(len);
        step();
        start_in = 1'b0;
        chk("busy_rise", 32'(busy_o), 32'(len != 0));
        for (int i = 0; i < len; i++) begin
            drive_sample(base + 16'(i + 1));
            chk("wr_lat", 32'(ram_wr_o), 32'(i % 2));
            if (i % 2 == 1) chk("wr_addr", 32'(ram_addr_o), 32'(HOFF + 4 * (i / 2)));
            if (i != len - 1) repeat (gap) step();
        end
        if (len != 0) begin
            if (len % 2 == 1) begin
                step();
                chk("flush_wr", 32'(ram_wr_o), 32'd1);
            end else begin
                chk("done_early", 32'(done_o), 32'd0);
            end
            step();
            chk("done_pulse", 32'(done_o), 32'd1);
            chk("irq_rise", 32'(irq_o), 32'd1);
        end
        repeat (4) step();
    endtask

    task automatic clear_irq();
        irq_clr_in = 1'b1;
        step();
        irq_clr_in = 1'b0;
        chk("irq_clr", 32'(irq_o), 32'd0);
    endtask

    initial begin
        int n0, d0, n0s, d0s;

        // Reset state (async, checked while held)
        #1;
        chk("rst_wr",   32'(ram_wr_o),     32'd0);
        chk("rst_addr", 32'(ram_addr_o),   32'd0);
        chk("rst_data", ram_data_o,        32'd0);
        chk("rst_busy", 32'(busy_o),       32'd0);
        chk("rst_done", 32'(done_o),       32'd0);
        chk("rst_irq",  32'(irq_o),        32'd0);
        chk("rst_ovf",  32'(overflow_o),   32'd0);
        chk("rst_wc",   32'(word_count_o), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

`ifdef AD9826_PACKER_HEADER_EN
        // Two header frames of length 4
        n0 = wa.size(); d0 = dn;
        run_frame(4, 16'h0000, 0);
        chk("h1_nwr", 32'(wa.size() - n0), 32'd3);
        if (wa.size() - n0 == 3) begin
            chk("h1_a0", 32'(wa[n0]),   32'd0); chk("h1_d0", wd[n0],   32'h0000_0004);
            chk("h1_a1", 32'(wa[n0+1]), 32'd4); chk("h1_d1", wd[n0+1], 32'h0002_0001);
            chk("h1_a2", 32'(wa[n0+2]), 32'd8); chk("h1_d2", wd[n0+2], 32'h0004_0003);
        end
        chk("h1_wc", 32'(word_count_o), 32'd3);
        clear_irq();
        n0 = wa.size();
        run_frame(4, 16'h0004, 1);
        chk("h2_nwr", 32'(wa.size() - n0), 32'd3);
        if (wa.size() - n0 == 3) begin
            chk("h2_a0", 32'(wa[n0]),   32'd0); chk("h2_d0", wd[n0],   32'h0001_0004);
            chk("h2_a1", 32'(wa[n0+1]), 32'd4); chk("h2_d1", wd[n0+1], 32'h0006_0005);
            chk("h2_a2", 32'(wa[n0+2]), 32'd8); chk("h2_d2", wd[n0+2], 32'h0008_0007);
        end
        chk("h_done", 32'(dn - d0), 32'd2);
`else
        // Length 8, back-to-back samples
        n0 = wa.size(); d0 = dn;
        run_frame(8, 16'h0000, 0);
        chk("t1_nwr", 32'(wa.size() - n0), 32'd4);
        if (wa.size() - n0 == 4)
            for (int k = 0; k < 4; k++) begin
                chk("t1_addr", 32'(wa[n0+k]), 32'(4 * k));
                chk("t1_data", wd[n0+k], {16'(2 * k + 2), 16'(2 * k + 1)});
            end
        chk("t1_done", 32'(dn - d0), 32'd1);
        chk("t1_irq",  32'(irq_o), 32'd1);
        chk("t1_wc",   32'(word_count_o), 32'd4);
        chk("t1_ovf",  32'(overflow_o), 32'd0);
        chk("t1_busy", 32'(busy_o), 32'd0);

        // Length 5 with gaps, irq_clr held through DONE (set must win)
        n0 = wa.size(); d0 = dn;
        irq_clr_in = 1'b1;
        run_frame(5, 16'hA000, 2);
        irq_clr_in = 1'b0;
        chk("t2_irq_cleared", 32'(irq_o), 32'd0);
        chk("t2_nwr", 32'(wa.size() - n0), 32'd3);
        if (wa.size() - n0 == 3) begin
            chk("t2_a0", 32'(wa[n0]),   32'd0); chk("t2_d0", wd[n0],   32'hA002_A001);
            chk("t2_a1", 32'(wa[n0+1]), 32'd4); chk("t2_d1", wd[n0+1], 32'hA004_A003);
            chk("t2_a2", 32'(wa[n0+2]), 32'd8); chk("t2_d2", wd[n0+2], 32'h0000_A005);
        end
        chk("t2_wc",   32'(word_count_o), 32'd3);
        chk("t2_done", 32'(dn - d0), 32'd1);

        // Length 0: no writes, one done, irq then cleared
        n0 = wa.size(); d0 = dn;
        run_frame(0, 16'h0000, 0);
        chk("t3_nwr",  32'(wa.size() - n0), 32'd0);
        chk("t3_done", 32'(dn - d0), 32'd1);
        chk("t3_irq",  32'(irq_o), 32'd1);
        chk("t3_wc",   32'(word_count_o), 32'd0);
        clear_irq();

        // Length 12 into 4-word window: truncation without wrap
        n0s = wa_s.size(); d0s = dn_s;
        run_frame(12, 16'h0000, 0);
        chk("t4_nwr", 32'(wa_s.size() - n0s), 32'd4);
        if (wa_s.size() - n0s == 4)
            for (int k = 0; k < 4; k++) begin
                chk("t4_addr", 32'(wa_s[n0s+k]), 32'(4 * k));
                chk("t4_data", wd_s[n0s+k], {16'(2 * k + 2), 16'(2 * k + 1)});
            end
        chk("t4_ovf",     32'(ovf_s), 32'd1);
        chk("t4_done",    32'(dn_s - d0s), 32'd1);
        chk("t4_wc",      32'(wc_s), 32'd4);
        chk("t4_big_ovf", 32'(overflow_o), 32'd0);
        chk("t4_big_wc",  32'(word_count_o), 32'd6);
        clear_irq();

        // Next frame must clear the sticky overflow on start
        run_frame(2, 16'h0000, 0);
        chk("t4_ovf_clr", 32'(ovf_s), 32'd0);

        // Repeated start mid-frame and on the last sample is ignored
        n0 = wa.size(); d0 = dn;
        start_in = 1'b1; length_in = 10'd4;
        step();
        start_in = 1'b0;
        drive_sample(16'h0001);
        drive_sample(16'h0002);
        start_in = 1'b1; length_in = 10'd2;
        drive_sample(16'h0003);
        drive_sample(16'h0004);
        start_in = 1'b0;
        step();
        chk("t5_done", 32'(done_o), 32'd1);
        repeat (4) step();
        chk("t5_nwr",  32'(wa.size() - n0), 32'd2);
        if (wa.size() - n0 == 2) begin
            chk("t5_d0", wd[n0],   32'h0002_0001);
            chk("t5_d1", wd[n0+1], 32'h0004_0003);
        end
        chk("t5_busy",  32'(busy_o), 32'd0);
        chk("t5_ndone", 32'(dn - d0), 32'd1);

        // Reset mid-frame (irq still set from previous frame)
        d0 = dn;
        start_in = 1'b1; length_in = 10'd8;
        step();
        start_in = 1'b0;
        drive_sample(16'h0011);
        drive_sample(16'h0012);
        drive_sample(16'h0013);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_wr",   32'(ram_wr_o), 32'd0);
        chk("t6_addr", 32'(ram_addr_o), 32'd0);
        chk("t6_data", ram_data_o, 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_irq",  32'(irq_o), 32'd0);
        chk("t6_wc",   32'(word_count_o), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("t6_ndone", 32'(dn - d0), 32'd0);
        chk("t6_irq2",  32'(irq_o), 32'd0);
        chk("t6_busy2", 32'(busy_o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
